// File: rtl/md_unit_param.sv
// Multiply/divide unit owning HI/LO: mult/multu/madd/maddu/div/divu take MULT_CYCLES/DIV_CYCLES, mthi/mtlo write immediately.
// The result is computed at accept into a shadow register and committed to HI/LO when the counter expires; done pulses after commit.
// No queueing: start is ignored while busy, flush aborts an in-flight op without touching HI/LO.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO  = 3'd5, OP_MADD = 3'd6, OP_MADDU = 3'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] shadow, shadow_nxt;
    logic               acc;

    logic accept, is_move, is_div, timed, commit;

    assign accept  = (state == IDLE) && start && !flush;
    assign is_move = (op == OP_MTHI) || (op == OP_MTLO);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign timed   = accept && !is_move;
    assign commit  = (state == RUN) && !flush && (cnt == CNT_ONE);

    // Arithmetic
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;

    always_comb begin
        a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
        b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
        a_zx   = {{WIDTH{1'b0}}, src_a};
        b_zx   = {{WIDTH{1'b0}}, src_b};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
        // Signed divide via magnitudes so most-negative / -1 wraps cleanly.
        neg_a  = (op == OP_DIV) && src_a[WIDTH-1];
        neg_b  = (op == OP_DIV) && src_b[WIDTH-1];
        mag_a  = neg_a ? -src_a : src_a;
        mag_b  = neg_b ? -src_b : src_b;
        div_b  = (mag_b == '0) ? WIDTH'(1) : mag_b;
        q_mag  = mag_a / div_b;
        r_mag  = mag_a % div_b;
        quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem    = neg_a ? -r_mag : r_mag;
        case (op)
            OP_MULT, OP_MADD:   shadow_nxt = prod_s;
            OP_MULTU, OP_MADDU: shadow_nxt = prod_u;
            OP_DIV, OP_DIVU:    shadow_nxt = {rem, quot};
            default:            shadow_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (timed) state_nxt = RUN;
            RUN:     if (flush || commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            shadow   <= '0;
            acc      <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && op == OP_MTHI) begin
                hi <= src_a;
            end else if (accept && op == OP_MTLO) begin
                lo <= src_a;
            end else if (timed) begin
                shadow   <= shadow_nxt;
                acc      <= (op == OP_MADD) || (op == OP_MADDU);
                cnt      <= is_div ? DIV_CNT : MULT_CNT;
                div_zero <= is_div && (src_b == '0);
            end else if (state == RUN) begin
                if (flush) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CNT_ONE;
                    if (commit) begin
                        done <= 1'b1;
                        // div_zero only stays set when the in-flight op is a zero divide.
                        if (acc)            {hi, lo} <= {hi, lo} + shadow;
                        else if (!div_zero) {hi, lo} <= shadow;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_md_unit_param.sv
// Directed test-plan scenarios plus randomized traffic, compared every cycle against a transaction-level model.
module tb_md_unit_param;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b, hi, lo;
    logic         busy, done, div_zero;

    md_unit_param #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit           m_busy, m_done, m_dz;
    int           m_left;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b, m_hi, m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
        m_op = '0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
    endtask

    function automatic void model_commit();
        longint          sp;
        longint unsigned up, hl;
        int              q, r;
        hl = {m_hi, m_lo};
        sp = longint'($signed(m_a)) * longint'($signed(m_b));
        up = {32'd0, m_a} * {32'd0, m_b};
        case (m_op)
            3'd0: {m_hi, m_lo} = sp;
            3'd1: {m_hi, m_lo} = up;
            3'd6: {m_hi, m_lo} = hl + sp;
            3'd7: {m_hi, m_lo} = hl + up;
            3'd2: if (m_b != 0) begin
                if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                    m_lo = m_a; m_hi = 0;
                end else begin
                    q = $signed(m_a) / $signed(m_b);
                    r = $signed(m_a) % $signed(m_b);
                    m_lo = q; m_hi = r;
                end
            end
            3'd3: if (m_b != 0) begin
                m_lo = m_a / m_b; m_hi = m_a % m_b;
            end
            default: ;
        endcase
    endfunction

    task automatic model_step();
        m_done = 0;
        if (m_busy) begin
            if (flush) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    model_commit();
                end
            end
        end else if (start && !flush) begin
            if (op == 3'd4) m_hi = src_a;
            else if (op == 3'd5) m_lo = src_a;
            else begin
                m_busy = 1; m_op = op; m_a = src_a; m_b = src_b;
                m_left = (op == 3'd2 || op == 3'd3) ? 10 : 5;
                m_dz   = (op == 3'd2 || op == 3'd3) && (src_b == 0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("div_zero", div_zero, m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        op = o; src_a = a; src_b = b; start = 1'b1;
        cycle();
        start = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 100) begin
            lat++;
            cycle();
        end
        chk("op_timeout", lat < 100, 1);
    endtask

    int lat;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);     chk("rst_lo", lo, 0);
        reset = 1'b0;

        // 1. mult / multu
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, lat);
        chk("mult_lat", lat, 5); chk("mult_done", done, 1);
        chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFA);
        cycle();
        chk("done_one_cycle", done, 0);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, lat);
        chk("multu_hi", hi, 32'h2); chk("multu_lo", lo, 32'hFFFF_FFFA);

        // 2. divide
        run_op(3'd3, 32'd7, 32'd2, lat);
        chk("divu_lat", lat, 10); chk("divu_lo", lo, 3); chk("divu_hi", hi, 1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD); chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div_ovf_lo", lo, 32'h8000_0000); chk("div_ovf_hi", hi, 0);

        // 3. divide by zero
        run_op(3'd4, 32'h11, 0, lat); chk("mthi_lat", lat, 0); chk("mthi_hi", hi, 32'h11);
        run_op(3'd5, 32'h22, 0, lat); chk("mtlo_lat", lat, 0); chk("mtlo_lo", lo, 32'h22);
        run_op(3'd2, 32'd5, 32'd0, lat);
        chk("dz_lat", lat, 10); chk("dz_done", done, 1); chk("dz_flag", div_zero, 1);
        chk("dz_hi", hi, 32'h11); chk("dz_lo", lo, 32'h22);
        run_op(3'd0, 32'd2, 32'd3, lat);
        chk("dz_cleared", div_zero, 0); chk("mult_small_lo", lo, 6);

        // 4. accumulate
        run_op(3'd4, 32'd0, 0, lat); run_op(3'd5, 32'hFFFF_FFFF, 0, lat);
        run_op(3'd6, 32'd1, 32'd1, lat);
        chk("madd_hi", hi, 1); chk("madd_lo", lo, 0);
        run_op(3'd4, 32'd0, 0, lat); run_op(3'd5, 32'd0, 0, lat);
        run_op(3'd7, 32'hFFFF_FFFF, 32'd2, lat);
        chk("maddu_hi", hi, 1); chk("maddu_lo", lo, 32'hFFFF_FFFE);

        // 5. start ignored while running, flush abort, flush+start in idle
        op = 3'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        op = 3'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; cycle(); start = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 100) begin lat++; cycle(); end
        chk("ignore_lo", lo, 14); chk("ignore_hi", hi, 2);
        cycle();
        chk("ignore_no_mult", busy, 0);
        op = 3'd0; src_a = 32'd1000; src_b = 32'd1000; start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("flush_busy", busy, 0); chk("flush_done", done, 0);
        chk("flush_lo", lo, 14); chk("flush_hi", hi, 2);
        cycle();
        chk("flush_no_late_done", done, 0);
        op = 3'd0; start = 1'b1; flush = 1'b1; cycle(); start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);
        op = 3'd4; src_a = 32'hDEAD; start = 1'b1; flush = 1'b1; cycle(); start = 1'b0; flush = 1'b0;
        chk("flush_start_mthi", hi, 2);

        // 6. async reset mid-divide
        op = 3'd2; src_a = 32'd5; src_b = 32'd0; start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        #2 reset = 1'b1;
        #1 model_reset();
        chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_dz", div_zero, 0);
        chk("arst_hi", hi, 0);     chk("arst_lo", lo, 0);
        reset = 1'b0;
        run_op(3'd0, 32'd6, 32'd7, lat);
        chk("post_rst_lat", lat, 5); chk("post_rst_lo", lo, 42); chk("post_rst_hi", hi, 0);

        // Random traffic: overlapping starts, flushes, zero divisors and corner operands
        for (int i = 0; i < 600; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: src_a = $urandom_range(0, 20);
                1: src_a = $urandom;
                2: src_a = 32'h8000_0000;
                default: src_a = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 5))
                0: src_b = 0;
                1, 2: src_b = $urandom_range(1, 20);
                3: src_b = 32'hFFFF_FFFF;
                default: src_b = $urandom;
            endcase
            start = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 24) == 0);
            cycle();
        end
        start = 1'b0; flush = 1'b0;
        repeat (12) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit holding the HI/LO architectural registers for the pipelined MIPS core.
- Sits beside the E-stage ALU.
- Generalises the fixed 5/10-cycle unit with configurable data width and latencies, multiply-accumulate ops, flush/abort for exception handling, a completion pulse and a divide-by-zero flag.
- The pipeline stalls md instructions in D while busy is high; this block never queues.

Parameters:
- WIDTH, 32, data width of operands, HI and LO.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu; must be >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled on rising clk edge.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- src_a  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data).
- src_b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort in-flight operation (exception / pipeline flush).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when a timed op commits HI/LO.
- div_zero  out  1  last accepted div/divu had src_b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0, shadow result=0.
- States are IDLE and RUN. busy is 1 exactly when state==RUN.
- Accept: on an edge with state==IDLE, start=1 and flush=0.
  - Ops 4 and 5 (mthi/mtlo): hi<=src_a or lo<=src_a at that edge. State stays IDLE, no busy, no done. div_zero unchanged.
  - Timed ops (0–3, 6, 7): latch the operands, load the counter with MULT_CYCLES or DIV_CYCLES, go to RUN, clear div_zero (div/divu set it to src_b==0).
- Start while RUN is ignored completely: no latch, no state change.
- RUN: the counter decrements each edge. busy stays high for exactly N cycles after the accept edge. On the edge where the counter goes 1->0:
  - HI/LO take the result.
  - State returns to IDLE.
  - done=1 for the following cycle only.
  - A start on that same edge is not accepted; the earliest accept is the next edge.
- hi/lo hold their old values for the whole RUN period.
- Arithmetic (all mod 2^(2*WIDTH) where relevant):
  - mult: signed full product, {hi,lo}=a*b.
  - multu: unsigned full product.
  - madd: {hi,lo} <= {hi,lo} + signed a*b, using the hi/lo values at commit time.
  - maddu: as madd, with an unsigned product.
  - div: lo = truncating signed quotient; hi = remainder with the sign of the dividend. Most-negative / -1 gives lo=most-negative, hi=0.
  - divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (div/divu with src_b==0): div_zero=1 from the accept edge. The op still takes DIV_CYCLES and done still pulses, but hi/lo are left unchanged.
- flush=1 on any edge:
  - If RUN: go to IDLE next edge; hi/lo unchanged, no done, div_zero keeps its value.
  - flush with start on the same edge: flush wins, start is ignored.
  - flush in IDLE: no effect.
- The result may be computed combinationally at accept into a shadow register. Only the commit timing is observable.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Test Plan (WIDTH=32, default latencies):
1. Signed multiply and multu: mult a=0xFFFFFFFE, b=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses 1 cycle. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
2. Divide: divu 7,2 -> after 10 busy cycles lo=3, hi=1. div 0xFFFFFFF9(-7),2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000,0xFFFFFFFF -> lo=0x80000000, hi=0.
3. Divide by zero: mthi 0x11, mtlo 0x22 (each immediate, busy stays 0), then div 5,0 -> div_zero=1, busy 10 cycles, done pulses, hi=0x11, lo=0x22 unchanged. A following mult clears div_zero.
4. Accumulate: mthi 0, mtlo 0xFFFFFFFF, madd 1,1 -> hi=1, lo=0. maddu 0xFFFFFFFF,2 from hi=0, lo=0 -> hi=1, lo=0xFFFFFFFE.
5. Ignore and flush: start mult during a div's cycle 3 -> ignored, div result intact. Separately, flush at busy cycle 3 of mult -> busy=0 next cycle, no done, hi/lo unchanged. flush+start on the same edge in IDLE -> nothing accepted.
6. Async reset: assert reset mid-div between clock edges -> hi, lo, busy, done, div_zero read 0 before the next clk edge. After release, a new mult completes normally.
